uart_tx_sched: RTL

//  Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.

---
 rtl/uart_ctrl_pkg.sv | 30 +++
 rtl/rr_pick.sv | 24 ++
 rtl/uart_tx_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control slice: scheduler state encoding,
// default byte width and constant-width helpers.
package uart_ctrl_pkg;

   localparam int DATA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } sched_state_t;

   // Ceiling log2, returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit after ptr,
// wrapping around, so the requester at ptr itself has lowest priority.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] index
);

   // Scan from farthest to nearest so the nearest set bit overwrites the rest.
   always_comb begin
      any   = |req;
      index = '0;
      for (int k = N; k >= 1; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            index = IDX_W'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// requesters, with a timeout guarding against a transmitter that never finishes.
module uart_tx_sched
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = DATA_W_DEFAULT,
   parameter int START_HOLD  = 16,
   parameter int TIMEOUT_CYC = 200000,
   localparam int ID_W       = clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      Tx_start,
   output logic [DATA_W-1:0]         data_in,
   input  logic                      tx_done,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy,
   output logic                      sent,
   output logic                      timeout_err
);

   localparam int CNT_W = clog2(max2(START_HOLD, TIMEOUT_CYC)) + 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   sched_state_t        state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  ready_q, ready_d;
   logic                start_q, start_d;
   logic                busy_q, busy_d;
   logic                sent_q, sent_d;
   logic                tmo_q, tmo_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tx_done_q;
   logic                done_rise;
   logic                pick_any;
   logic [ID_W-1:0]     pick_idx;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .any   (pick_any),
      .index (pick_idx)
   );

   // Only a fresh rising edge counts, so a done level left over from an
   // earlier byte cannot complete the current one.
   assign done_rise = tx_done & ~tx_done_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      ready_d = '0;
      start_d = start_q;
      busy_d  = busy_q;
      sent_d  = 1'b0;
      tmo_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               data_d  = req_data[pick_idx*DATA_W +: DATA_W];
               grant_d = pick_idx;
               ready_d = NUM_REQ'(1) << pick_idx;
               ptr_d   = pick_idx;
               start_d = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (done_rise) begin
               start_d = 1'b0;
               sent_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == HOLD_LAST) begin
               start_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT: begin
            // A completion in the final timeout cycle still counts as success.
            if (done_rise) begin
               sent_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == TMO_LAST) begin
               tmo_d   = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            start_d = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pointer resets to the last requester so requester 0 is granted first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         grant_q   <= '0;
         ptr_q     <= ID_W'(NUM_REQ - 1);
         ready_q   <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         sent_q    <= 1'b0;
         tmo_q     <= 1'b0;
         cnt_q     <= '0;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         ready_q   <= ready_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         sent_q    <= sent_d;
         tmo_q     <= tmo_d;
         cnt_q     <= cnt_d;
         tx_done_q <= tx_done;
      end
   end

   assign req_ready   = ready_q;
   assign Tx_start    = start_q;
   assign data_in     = data_q;
   assign grant_id    = grant_q;
   assign busy        = busy_q;
   assign sent        = sent_q;
   assign timeout_err = tmo_q;

endmodule
